// File: rtl/mandel_frame_sequencer_if.sv
// Engine-side and framebuffer-side bus of the Mandelbrot frame sequencer.
// master = sequencer, slave = engines plus framebuffer write port.
interface mandel_frame_sequencer_if #(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int OUTWIDTH = 4,
  parameter int LANES    = 2
);
  logic [CTRWIDTH-1:0]       max_ctr;
  logic [LANES-1:0]          lane_run;
  logic [LANES*BITWIDTH-1:0] lane_cr;
  logic [LANES*BITWIDTH-1:0] lane_ci;
  logic [LANES-1:0]          lane_running;
  logic [LANES*OUTWIDTH-1:0] lane_ctr;
  logic                      fb_rst_ptr;
  logic [OUTWIDTH-1:0]       fb_data;
  logic                      fb_valid;
  logic                      fb_ready;

  modport master (
    output max_ctr, lane_run, lane_cr, lane_ci, fb_rst_ptr, fb_data, fb_valid,
    input  lane_running, lane_ctr, fb_ready
  );

  modport slave (
    input  max_ctr, lane_run, lane_cr, lane_ci, fb_rst_ptr, fb_data, fb_valid,
    output lane_running, lane_ctr, fb_ready
  );
endinterface

// File: rtl/mandel_frame_sequencer.sv
// Raster-order frame walker: batches pixels onto LANES engines, streams results in order.
// States: IDLE -> RSTPTR -> ISSUE <-> COLLECT -> DONE -> IDLE (abort returns to IDLE).
module mandel_frame_sequencer #(
  parameter int BITWIDTH = 11,
  parameter int CTRWIDTH = 7,
  parameter int OUTWIDTH = 4,
  parameter int LANES    = 2,
  parameter int H_PIXELS = 80,
  parameter int V_PIXELS = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic cfg_shift_en,
  input  logic cfg_data,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  mandel_frame_sequencer_if.master bus
);
  localparam int CFG_LEN = CTRWIDTH + 3*BITWIDTH;
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int XW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
  localparam int YW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0,
                         S_RSTPTR  = 3'd1,
                         S_ISSUE   = 3'd2,
                         S_COLLECT = 3'd3,
                         S_DONE    = 3'd4;

  logic [2:0]          state;
  logic [CFG_LEN-1:0]  cfg;
  logic [CTRWIDTH-1:0] max_q;
  logic [BITWIDTH-1:0] step_q, cr0_q, ci0_q;
  logic [XW-1:0]       x, nx;
  logic [YW-1:0]       y, ny;
  logic [BITWIDTH-1:0] cr, ci, ncr, nci;
  logic                more, nmore;
  logic [BITWIDTH-1:0] hold_cr [LANES];
  logic [BITWIDTH-1:0] hold_ci [LANES];
  logic [BITWIDTH-1:0] slot_cr [LANES];
  logic [BITWIDTH-1:0] slot_ci [LANES];
  logic [OUTWIDTH-1:0] result  [LANES];
  logic [LANES-1:0]    pending, captured, prev_running, slot_en;
  logic [IW-1:0]       emit_idx, last_idx, slot_last;
  logic                issuing, accept, emit_last;

  // Walk up to LANES pixels ahead of the current position to build the next batch.
  always_comb begin
    nx        = x;
    ny        = y;
    ncr       = cr;
    nci       = ci;
    nmore     = 1'b1;
    slot_en   = '0;
    slot_last = '0;
    for (int i = 0; i < LANES; i++) begin
      slot_cr[i] = ncr;
      slot_ci[i] = nci;
      if (nmore) begin
        slot_en[i] = 1'b1;
        slot_last  = IW'(i);
        if (nx == XW'(H_PIXELS-1)) begin
          nmore = (ny != YW'(V_PIXELS-1));
          nx    = '0;
          ny    = ny + 1'b1;
          ncr   = cr0_q;
          nci   = nci + step_q;
        end else begin
          nx  = nx + 1'b1;
          ncr = ncr + step_q;
        end
      end
    end
  end

  assign issuing        = (state == S_ISSUE);
  assign done           = (state == S_DONE);
  assign bus.fb_rst_ptr = (state == S_RSTPTR);
  assign bus.max_ctr    = max_q;
  assign bus.lane_run   = issuing ? slot_en : '0;
  assign bus.fb_valid   = (state == S_COLLECT) && captured[emit_idx];
  assign bus.fb_data    = result[emit_idx];
  assign accept         = bus.fb_valid && bus.fb_ready;
  assign emit_last      = (emit_idx == last_idx);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign bus.lane_cr[g*BITWIDTH +: BITWIDTH] = (issuing && slot_en[g]) ? slot_cr[g] : hold_cr[g];
    assign bus.lane_ci[g*BITWIDTH +: BITWIDTH] = (issuing && slot_en[g]) ? slot_ci[g] : hold_ci[g];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cfg          <= '0;
      max_q        <= '0;
      step_q       <= '0;
      cr0_q        <= '0;
      ci0_q        <= '0;
      x            <= '0;
      y            <= '0;
      cr           <= '0;
      ci           <= '0;
      more         <= 1'b0;
      busy         <= 1'b0;
      pending      <= '0;
      captured     <= '0;
      prev_running <= '0;
      emit_idx     <= '0;
      last_idx     <= '0;
      for (int i = 0; i < LANES; i++) begin
        hold_cr[i] <= '0;
        hold_ci[i] <= '0;
        result[i]  <= '0;
      end
    end else begin
      prev_running <= bus.lane_running;
      if (cfg_shift_en)
        cfg <= {cfg[CFG_LEN-2:0], cfg_data};
      // Falling edge of an engine's running flag latches its result until emitted.
      for (int i = 0; i < LANES; i++) begin
        if (pending[i] && prev_running[i] && !bus.lane_running[i]) begin
          result[i]   <= bus.lane_ctr[i*OUTWIDTH +: OUTWIDTH];
          captured[i] <= 1'b1;
          pending[i]  <= 1'b0;
        end
      end
      if (abort && state != S_IDLE) begin
        state    <= S_IDLE;
        busy     <= 1'b0;
        pending  <= '0;
        captured <= '0;
        emit_idx <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              {max_q, step_q, ci0_q, cr0_q} <= cfg;
              busy  <= 1'b1;
              state <= S_RSTPTR;
            end
          end
          S_RSTPTR: begin
            x     <= '0;
            y     <= '0;
            cr    <= cr0_q;
            ci    <= ci0_q;
            state <= S_ISSUE;
          end
          S_ISSUE: begin
            x        <= nx;
            y        <= ny;
            cr       <= ncr;
            ci       <= nci;
            more     <= nmore;
            last_idx <= slot_last;
            emit_idx <= '0;
            pending  <= slot_en;
            for (int i = 0; i < LANES; i++) begin
              if (slot_en[i]) begin
                hold_cr[i] <= slot_cr[i];
                hold_ci[i] <= slot_ci[i];
              end
            end
            state <= S_COLLECT;
          end
          S_COLLECT: begin
            if (accept) begin
              captured[emit_idx] <= 1'b0;
              if (emit_last) begin
                emit_idx <= '0;
                state    <= more ? S_ISSUE : S_DONE;
              end else begin
                emit_idx <= emit_idx + 1'b1;
              end
            end
          end
          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mandel_frame_sequencer.sv
// Bench for mandel_frame_sequencer: engine stand-ins, random framebuffer backpressure,
// and a pixel-index reference model of the expected raster walk.
module tb_mandel_frame_sequencer;
  localparam int BW = 11, CW = 7, OW = 4, LN = 2, HP = 3, VP = 3;
  localparam int NPIX = HP*VP;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cfg_shift_en, cfg_data, start, abort;
  logic busy, done;

  mandel_frame_sequencer_if #(.BITWIDTH(BW), .CTRWIDTH(CW), .OUTWIDTH(OW), .LANES(LN)) bus();

  mandel_frame_sequencer #(
    .BITWIDTH(BW), .CTRWIDTH(CW), .OUTWIDTH(OW), .LANES(LN), .H_PIXELS(HP), .V_PIXELS(VP)
  ) dut (
    .clk(clk), .reset(reset), .cfg_shift_en(cfg_shift_en), .cfg_data(cfg_data),
    .start(start), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int issue_ptr, out_ptr, done_cnt, rst_cnt;
  int ready_mode;
  int lat_lo [LN];
  int lat_hi [LN];
  logic [CW-1:0] m_max;
  logic [BW-1:0] m_step, m_ci0, m_cr0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stand-in for an engine's iteration count: any fixed function of the coordinates.
  function automatic logic [OW-1:0] pix_val(input logic [BW-1:0] c_r, input logic [BW-1:0] c_i);
    logic [BW-1:0] t;
    t = c_r ^ {c_i[4:0], c_i[10:5]} ^ (c_r >> 5);
    return t[3:0] ^ t[7:4] ^ {1'b0, t[10:8]};
  endfunction

  function automatic logic [BW-1:0] exp_cr(input int p);
    return BW'(int'(m_cr0) + (p % HP) * int'(m_step));
  endfunction

  function automatic logic [BW-1:0] exp_ci(input int p);
    return BW'(int'(m_ci0) + (p / HP) * int'(m_step));
  endfunction

  // Engine models: running rises the cycle after lane_run, falls after a random latency.
  int eng_cnt [LN];
  logic [BW-1:0] eng_cr [LN];
  logic [BW-1:0] eng_ci [LN];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.lane_running <= '0;
      bus.lane_ctr     <= '0;
      for (int i = 0; i < LN; i++) eng_cnt[i] <= 0;
    end else begin
      for (int i = 0; i < LN; i++) begin
        if (bus.lane_run[i]) begin
          bus.lane_running[i] <= 1'b1;
          eng_cnt[i] <= int'($urandom_range(lat_hi[i], lat_lo[i]));
          eng_cr[i]  <= bus.lane_cr[i*BW +: BW];
          eng_ci[i]  <= bus.lane_ci[i*BW +: BW];
        end else if (bus.lane_running[i]) begin
          if (eng_cnt[i] == 0) begin
            bus.lane_running[i] <= 1'b0;
            bus.lane_ctr[i*OW +: OW] <= pix_val(eng_cr[i], eng_ci[i]);
          end else begin
            eng_cnt[i] <= eng_cnt[i] - 1;
          end
        end
      end
    end
  end

  // Monitor: issued batches and accepted writes against the raster model.
  initial forever begin
    @(negedge clk);
    if (!reset && !abort) begin
      if (bus.lane_run != '0) begin
        int n;
        n = NPIX - issue_ptr;
        if (n > LN) n = LN;
        if (n < 0) n = 0;
        check_eq("run_mask", 64'(bus.lane_run), (64'd1 << n) - 64'd1);
        check_eq("max_ctr", 64'(bus.max_ctr), 64'(m_max));
        for (int i = 0; i < n; i++) begin
          check_eq("lane_cr", 64'(bus.lane_cr[i*BW +: BW]), 64'(exp_cr(issue_ptr + i)));
          check_eq("lane_ci", 64'(bus.lane_ci[i*BW +: BW]), 64'(exp_ci(issue_ptr + i)));
        end
        issue_ptr += n;
      end
      if (bus.fb_valid && bus.fb_ready) begin
        check_eq("fb_data", 64'(bus.fb_data), 64'(pix_val(exp_cr(out_ptr), exp_ci(out_ptr))));
        out_ptr++;
      end
      if (done) done_cnt++;
      if (bus.fb_rst_ptr) rst_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       bus.fb_ready = ($urandom_range(3, 0) != 0);
      1:       bus.fb_ready = 1'b1;
      default: bus.fb_ready = 1'b0;
    endcase
  endtask

  task automatic shift_cfg(input logic [CW+3*BW-1:0] v);
    for (int i = CW+3*BW-1; i >= 0; i--) begin
      cfg_shift_en = 1'b1;
      cfg_data     = v[i];
      tick();
    end
    cfg_shift_en = 1'b0;
    cfg_data     = 1'b0;
  endtask

  task automatic begin_frame(input logic [CW-1:0] mx, input logic [BW-1:0] st,
                             input logic [BW-1:0] ci0, input logic [BW-1:0] cr0, input bit do_shift);
    if (do_shift) shift_cfg({mx, st, ci0, cr0});
    m_max = mx; m_step = st; m_ci0 = ci0; m_cr0 = cr0;
    issue_ptr = 0; out_ptr = 0; done_cnt = 0; rst_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [CW-1:0] mx, input logic [BW-1:0] st,
                           input logic [BW-1:0] ci0, input logic [BW-1:0] cr0,
                           input int rmode, input bit do_shift, input bit noise,
                           input bit order_chk, input bit stall_chk);
    logic [OW-1:0] held;
    ready_mode = rmode;
    begin_frame(mx, st, ci0, cr0, do_shift);
    @(negedge clk);
    check_eq("rst_ptr_lat", 64'(bus.fb_rst_ptr), 64'd1);
    check_eq("busy_start", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check_eq("run_lat", 64'(bus.lane_run[0]), 64'd1);
    if (order_chk) begin
      tick();
      for (int c = 0; c < 40; c++) begin
        if (!bus.lane_running[0]) break;
        check_eq("valid_wait_lane0", 64'(bus.fb_valid), 64'd0);
        tick();
      end
      check_eq("lane1_first", 64'(bus.lane_running[1]), 64'd0);
    end
    if (stall_chk) begin
      ready_mode = 2;
      for (int c = 0; c < 100; c++) begin
        tick();
        if (bus.fb_valid) break;
      end
      check_eq("stall_valid", 64'(bus.fb_valid), 64'd1);
      held = bus.fb_data;
      for (int c = 0; c < 10; c++) begin
        tick();
        check_eq("stall_data", 64'(bus.fb_data), 64'(held));
        check_eq("stall_norun", 64'(bus.lane_run), 64'd0);
      end
      ready_mode = rmode;
    end
    for (int c = 0; c < 3000 && done_cnt == 0; c++) begin
      tick();
      if (noise) begin
        cfg_shift_en = 1'($urandom_range(1, 0));
        cfg_data     = 1'($urandom_range(1, 0));
        start        = (out_ptr < NPIX) && ($urandom_range(7, 0) == 0);
      end
    end
    start = 1'b0;
    cfg_shift_en = 1'b0;
    check_eq("done_seen", 64'(done_cnt), 64'd1);
    tick();
    tick();
    check_eq("busy_end", 64'(busy), 64'd0);
    check_eq("writes", 64'(out_ptr), 64'(NPIX));
    check_eq("issued", 64'(issue_ptr), 64'(NPIX));
    check_eq("done_once", 64'(done_cnt), 64'd1);
    check_eq("rst_ptr_once", 64'(rst_cnt), 64'd1);
  endtask

  task automatic wait_lanes_idle();
    for (int c = 0; c < 100; c++) begin
      if (bus.lane_running == '0) break;
      tick();
    end
    check_eq("lanes_idle", 64'(bus.lane_running), 64'd0);
  endtask

  task automatic run_abort();
    ready_mode = 0;
    begin_frame(7'd33, 11'd9, 11'd5, 11'd17, 1'b1);
    for (int c = 0; c < 500 && out_ptr < 2; c++) tick();
    for (int c = 0; c < 100; c++) begin
      if (busy && bus.lane_run == '0 && !bus.fb_rst_ptr && !done) break;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_valid", 64'(bus.fb_valid), 64'd0);
    repeat (20) tick();
    check_eq("abort_nodone", 64'(done_cnt), 64'd0);
    wait_lanes_idle();
  endtask

  task automatic run_async_reset();
    ready_mode = 0;
    begin_frame(7'd12, 11'd3, 11'd40, 11'd50, 1'b1);
    for (int c = 0; c < 200 && issue_ptr < 2; c++) tick();
    #1;
    reset = 1'b1;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_valid", 64'(bus.fb_valid), 64'd0);
    check_eq("arst_run", 64'(bus.lane_run), 64'd0);
    check_eq("arst_max", 64'(bus.max_ctr), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_eq("arst_nodone", 64'(done_cnt), 64'd0);
  endtask

  initial begin
    cfg_shift_en = 1'b0; cfg_data = 1'b0; start = 1'b0; abort = 1'b0;
    bus.fb_ready = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < LN; i++) begin lat_lo[i] = 2; lat_hi[i] = 2; end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_valid", 64'(bus.fb_valid), 64'd0);
    check_eq("rst_fbptr", 64'(bus.fb_rst_ptr), 64'd0);
    check_eq("rst_run", 64'(bus.lane_run), 64'd0);
    check_eq("rst_max", 64'(bus.max_ctr), 64'd0);
    check_eq("rst_data", 64'(bus.fb_data), 64'd0);
    check_eq("rst_cr", 64'(bus.lane_cr), 64'd0);
    tick();
    reset = 1'b0;
    tick();

    run_frame(7'd20, 11'd4, 11'd0, 11'd0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(7'd20, 11'd4, 11'h100, 11'h7FC, 1, 1'b1, 1'b0, 1'b0, 1'b0);

    lat_lo[0] = 8; lat_hi[0] = 8; lat_lo[1] = 3; lat_hi[1] = 3;
    run_frame(7'd5, 11'd7, 11'd3, 11'd1, 1, 1'b1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < LN; i++) begin lat_lo[i] = 0; lat_hi[i] = 4; end
    run_frame(7'd90, 11'd21, 11'd64, 11'd2, 0, 1'b1, 1'b0, 1'b0, 1'b1);

    run_abort();
    run_frame(7'd33, 11'd9, 11'd5, 11'd17, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    run_async_reset();
    run_frame(7'd0, 11'd0, 11'd0, 11'd0, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < LN; i++) begin lat_lo[i] = 0; lat_hi[i] = 6; end
    for (int f = 0; f < 12; f++) begin
      run_frame(7'($urandom), 11'($urandom), 11'($urandom), 11'($urandom), 0, 1'b1, 1'b1, 1'b0, 1'b0);
      wait_lanes_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
